// File: rtl/cache_tg_pkg.sv
// Shared types and constants for the cache traffic generator.
// Widths are derived from the parameters of the instantiating module.
package cache_tg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_GAP,
        ST_FLUSH,
        ST_DONE
    } tg_state_e;

    localparam int MODE_STRIDE_BIT = 0;
    localparam int MODE_WRITE_BIT  = 1;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cache_tg_pattern_gen.sv
// Combinational address and data-pattern generator for one request index.
// Address arithmetic wraps modulo 2^ADDR_W.
module cache_tg_pattern_gen
    import cache_tg_pkg::*;
#(
    parameter int                ADDR_W = 28,
    parameter int                DATA_W = 32,
    parameter int                IDX_W  = 4,
    parameter logic [ADDR_W-1:0] STRIDE = 28'h100_0000,
    parameter logic [DATA_W-1:0] SEED   = 32'hA5A5_0000
) (
    input  logic [IDX_W-1:0]  idx,
    input  logic              stride_sel,
    input  logic [ADDR_W-1:0] base,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pattern
);

    logic [ADDR_W-1:0] offset;

    always_comb begin
        if (stride_sel) begin
            offset = ADDR_W'(idx) * STRIDE;
        end else begin
            offset = ADDR_W'(idx);
        end
    end

    assign addr    = base + offset;
    assign pattern = SEED ^ DATA_W'(addr);

endmodule

// File: rtl/cache_traffic_gen.sv
// Cache request generator: read or write+readback bursts with optional flush,
// per-request timeout and readback error counting.
module cache_traffic_gen
    import cache_tg_pkg::*;
#(
    parameter int                ADDR_W  = 28,
    parameter int                DATA_W  = 32,
    parameter int                N_REQ   = 16,
    parameter logic [ADDR_W-1:0] STRIDE  = 28'h100_0000,
    parameter logic [DATA_W-1:0] SEED    = 32'hA5A5_0000,
    parameter int                TIMEOUT = 1024,
    parameter int                ERR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              do_flush,
    input  logic [ADDR_W-1:0] base_addr,
    output logic [ADDR_W-1:0] cache_addr,
    output logic [DATA_W-1:0] cache_wr,
    output logic              cache_rw,
    output logic              cache_valid,
    output logic              flush,
    input  logic [DATA_W-1:0] cache_rd,
    input  logic              cache_ready,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [ADDR_W-1:0] first_err_addr,
    output logic              timeout
);

    localparam int IDX_W = cnt_width(N_REQ);
    localparam int TMO_W = cnt_width(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    tg_state_e         state, next_state;
    logic [IDX_W-1:0]  idx;
    logic              write_pass;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q;
    logic              flush_q;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_pattern;
    logic              last_idx;
    logic              tmo_hit;
    logic              readback_hit;

    cache_tg_pattern_gen #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .STRIDE (STRIDE),
        .SEED   (SEED)
    ) u_pattern (
        .idx        (idx),
        .stride_sel (mode_q[MODE_STRIDE_BIT]),
        .base       (base_q),
        .addr       (req_addr),
        .pattern    (req_pattern)
    );

    assign last_idx = (idx == LAST_IDX);
    // tmo_cnt counts valid cycles already spent on the current request.
    assign tmo_hit  = (tmo_cnt == TMO_LAST);
    assign readback_hit = (state == ST_WAIT) && cache_ready && !write_pass
                          && mode_q[MODE_WRITE_BIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        cache_valid = 1'b0;
        cache_rw    = 1'b0;
        flush       = 1'b0;
        cache_addr  = '0;
        cache_wr    = '0;
        done        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) next_state = ST_ISSUE;
            end
            ST_ISSUE, ST_WAIT: begin
                cache_valid = 1'b1;
                cache_rw    = write_pass;
                cache_addr  = req_addr;
                cache_wr    = write_pass ? req_pattern : '0;
                if (state == ST_ISSUE) begin
                    next_state = ST_WAIT;
                end else if (cache_ready) begin
                    next_state = ST_GAP;
                end else if (tmo_hit) begin
                    next_state = ST_DONE;
                end
            end
            ST_GAP: begin
                if (!last_idx || write_pass) begin
                    next_state = ST_ISSUE;
                end else if (flush_q) begin
                    next_state = ST_FLUSH;
                end else begin
                    next_state = ST_DONE;
                end
            end
            ST_FLUSH: begin
                cache_valid = 1'b1;
                flush       = 1'b1;
                if (cache_ready || tmo_hit) next_state = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        busy = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx            <= '0;
            write_pass     <= 1'b0;
            mode_q         <= '0;
            base_q         <= '0;
            flush_q        <= 1'b0;
            err_cnt        <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                idx            <= '0;
                write_pass     <= mode[MODE_WRITE_BIT];
                mode_q         <= mode;
                base_q         <= base_addr;
                flush_q        <= do_flush;
                err_cnt        <= '0;
                first_err_addr <= '0;
                timeout        <= 1'b0;
            end
            // End of the write pass rewinds the index for the readback pass.
            if (state == ST_GAP && (!last_idx || write_pass)) begin
                if (last_idx) begin
                    idx        <= '0;
                    write_pass <= 1'b0;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
            if ((state == ST_WAIT || state == ST_FLUSH) && !cache_ready && tmo_hit) begin
                timeout <= 1'b1;
            end
            // err_cnt is zero exactly until the first mismatch, so it gates the capture.
            if (readback_hit && cache_rd != req_pattern) begin
                if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                if (err_cnt == '0) first_err_addr <= req_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
        end else if (state == ST_ISSUE || state == ST_WAIT || state == ST_FLUSH) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
        end else begin
            tmo_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_cache_traffic_gen.sv
// Self-checking bench: randomized cache responder plus a request-queue model
// of the generator, compared against the DUT every cycle.
module tb_cache_traffic_gen;

    localparam int ADDR_W  = 28;
    localparam int DATA_W  = 32;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 64;
    localparam int ERR_W   = 16;
    localparam logic [ADDR_W-1:0] STRIDE = 28'h100_0000;
    localparam logic [DATA_W-1:0] SEED   = 32'hA5A5_0000;

    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_GAP  = 2;
    localparam int PH_DONE = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [1:0]        mode = '0;
    logic              do_flush = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic [ADDR_W-1:0] cache_addr;
    logic [DATA_W-1:0] cache_wr;
    logic              cache_rw;
    logic              cache_valid;
    logic              flush;
    logic [DATA_W-1:0] cache_rd = '0;
    logic              cache_ready = 1'b0;
    logic              busy;
    logic              done;
    logic [ERR_W-1:0]  err_cnt;
    logic [ADDR_W-1:0] first_err_addr;
    logic              timeout;

    cache_traffic_gen #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .N_REQ (N_REQ), .STRIDE (STRIDE),
        .SEED (SEED), .TIMEOUT (TIMEOUT), .ERR_W (ERR_W)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .mode (mode), .do_flush (do_flush),
        .base_addr (base_addr), .cache_addr (cache_addr), .cache_wr (cache_wr),
        .cache_rw (cache_rw), .cache_valid (cache_valid), .flush (flush),
        .cache_rd (cache_rd), .cache_ready (cache_ready), .busy (busy), .done (done),
        .err_cnt (err_cnt), .first_err_addr (first_err_addr), .timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              rw;
        logic              fl;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b0;

    // Model state
    req_t             exp_q[$];
    int               ph = PH_IDLE;
    int               ptr = 0;
    int               vcyc = 0;
    logic [1:0]       m_mode = '0;
    logic [ERR_W-1:0] m_err = '0;
    logic [ADDR_W-1:0] m_first = '0;
    logic             m_to = 1'b0;

    // Responder state
    logic [DATA_W-1:0] mem [logic [ADDR_W-1:0]];
    req_t              seen[$];
    bit                stuck = 1'b0;
    int                corrupt_at = -1;
    int                rd_num = 0;
    int                rvc = 0;
    int                dly = 0;
    int                vcount = 0;
    int                done_cnt = 0;
    logic [DATA_W-1:0] rdata;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ADDR_W-1:0] b,
                                                  input logic [1:0] m, input int i);
        longint off;
        off = m[0] ? longint'(i) * longint'(STRIDE) : longint'(i);
        return ADDR_W'(longint'(b) + off);
    endfunction

    function automatic logic [DATA_W-1:0] pat_of(input logic [ADDR_W-1:0] a);
        return SEED ^ {{(DATA_W-ADDR_W){1'b0}}, a};
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Request-level model: expected requests queued at start, advanced on completions.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph = PH_IDLE; ptr = 0; vcyc = 0;
            m_err = '0; m_first = '0; m_to = 1'b0;
        end else begin
            case (ph)
                PH_IDLE: if (start) begin
                    exp_q.delete();
                    m_mode = mode;
                    if (mode[1])
                        for (int i = 0; i < N_REQ; i++)
                            exp_q.push_back('{1'b1, 1'b0, addr_of(base_addr, mode, i),
                                              pat_of(addr_of(base_addr, mode, i))});
                    for (int i = 0; i < N_REQ; i++)
                        exp_q.push_back('{1'b0, 1'b0, addr_of(base_addr, mode, i),
                                          pat_of(addr_of(base_addr, mode, i))});
                    if (do_flush) exp_q.push_back('{1'b0, 1'b1, '0, '0});
                    ptr = 0; vcyc = 0;
                    m_err = '0; m_first = '0; m_to = 1'b0;
                    ph = PH_REQ;
                end
                PH_REQ: begin
                    vcyc++;
                    if (cache_ready && vcyc >= 2) begin
                        if (m_mode[1] && !exp_q[ptr].rw && !exp_q[ptr].fl
                            && cache_rd !== exp_q[ptr].data) begin
                            if (m_err == '0) m_first = exp_q[ptr].addr;
                            if (m_err != '1) m_err = m_err + 1'b1;
                        end
                        ph = exp_q[ptr].fl ? PH_DONE : PH_GAP;
                        ptr++;
                    end else if (vcyc == TIMEOUT) begin
                        m_to = 1'b1;
                        ph = PH_DONE;
                    end
                end
                PH_GAP: begin
                    ph = (ptr < exp_q.size()) ? PH_REQ : PH_DONE;
                    vcyc = 0;
                end
                default: ph = PH_IDLE;
            endcase
        end
    end

    // Responder: ready after 1..4 valid cycles, memory-backed reads, optional corruption.
    always @(negedge clk) begin
        if (cache_valid) begin
            rvc++;
            if (!stuck && !cache_ready && rvc >= dly + 2) begin
                cache_ready = 1'b1;
                rdata = '0;
                if (cache_rw) begin
                    mem[cache_addr] = cache_wr;
                end else if (!flush) begin
                    rdata = mem.exists(cache_addr) ? mem[cache_addr] : DATA_W'($urandom);
                    if (rd_num == corrupt_at) rdata = '0;
                    rd_num++;
                    cache_rd = rdata;
                end
                seen.push_back('{cache_rw, flush, cache_addr, cache_rw ? cache_wr : rdata});
            end else begin
                cache_ready = 1'b0;
                cache_rd = DATA_W'($urandom);
            end
            vcount++;
        end else begin
            rvc = 0;
            cache_ready = 1'b0;
            cache_rd = DATA_W'($urandom);
            dly = $urandom_range(0, 3);
        end
        if (done) done_cnt++;
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (rst && chk_en) begin
            check_output("busy", 64'(busy), 64'(ph != PH_IDLE));
            check_output("done", 64'(done), 64'(ph == PH_DONE));
            check_output("cache_valid", 64'(cache_valid), 64'(ph == PH_REQ));
            check_output("flush", 64'(flush), 64'((ph == PH_REQ) ? exp_q[ptr].fl : 1'b0));
            if (ph == PH_REQ) begin
                check_output("cache_rw", 64'(cache_rw), 64'(exp_q[ptr].rw));
                if (!exp_q[ptr].fl) check_output("cache_addr", 64'(cache_addr), 64'(exp_q[ptr].addr));
                if (exp_q[ptr].rw) check_output("cache_wr", 64'(cache_wr), 64'(exp_q[ptr].data));
            end
            check_output("err_cnt", 64'(err_cnt), 64'(m_err));
            check_output("first_err_addr", 64'(first_err_addr), 64'(m_first));
            check_output("timeout", 64'(timeout), 64'(m_to));
        end
    end

    task automatic apply_stimulus(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                                  input logic f, input int corrupt, input bit stk);
        @(negedge clk);
        mode = m; base_addr = b; do_flush = f;
        corrupt_at = corrupt; stuck = stk; rd_num = 0;
        seen.delete(); vcount = 0; done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode = 2'($urandom); base_addr = ADDR_W'($urandom); do_flush = 1'($urandom);
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!done) check_output("done_wait", 64'(0), 64'(1));
        @(negedge clk);
    endtask

    task automatic run(input logic [1:0] m, input logic [ADDR_W-1:0] b,
                       input logic f, input int corrupt, input bit stk);
        apply_stimulus(m, b, f, corrupt, stk);
        wait_done(600);
    endtask

    task automatic check_reset_outputs();
        check_output("rst_addr", 64'(cache_addr), 64'(0));
        check_output("rst_wr", 64'(cache_wr), 64'(0));
        check_output("rst_valid", 64'({cache_rw, cache_valid, flush}), 64'(0));
        check_output("rst_status", 64'({busy, done, timeout}), 64'(0));
        check_output("rst_err", 64'(err_cnt), 64'(0));
        check_output("rst_first", 64'(first_err_addr), 64'(0));
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b1;
        chk_en = 1'b1;

        $display("[TB] read-only unit step");
        run(2'b00, 28'h0, 1'b0, -1, 1'b0);
        check_output("ro_count", 64'(seen.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check_output("ro_addr", 64'(seen[i].addr), 64'(i));
            check_output("ro_rw", 64'(seen[i].rw), 64'(0));
        end
        check_output("ro_done_cnt", 64'(done_cnt), 64'(1));

        $display("[TB] conflict writes then readback");
        run(2'b11, 28'h000_1018, 1'b0, -1, 1'b0);
        check_output("model_pat3", 64'(exp_q[3].data), 64'(32'hA6A5_1018));
        check_output("wb_addr1", 64'(seen[1].addr), 64'(28'h100_1018));
        check_output("wb_wr0", 64'(seen[0].data), 64'(32'hA5A5_1018));
        check_output("wb_wr2", 64'(seen[2].data), 64'(32'hA7A5_1018));
        check_output("wb_rd3_addr", 64'(seen[7].addr), 64'(28'h300_1018));
        check_output("wb_rd3_rw", 64'(seen[7].rw), 64'(0));
        check_output("wb_err", 64'(err_cnt), 64'(0));

        $display("[TB] corrupted readback");
        run(2'b11, 28'h000_1018, 1'b0, 2, 1'b0);
        check_output("cr_err", 64'(err_cnt), 64'(1));
        check_output("cr_first", 64'(first_err_addr), 64'(28'h200_1018));

        $display("[TB] stuck cache");
        run(2'b00, 28'h123, 1'b0, -1, 1'b1);
        check_output("st_timeout", 64'(timeout), 64'(1));
        check_output("st_valid_cycles", 64'(vcount), 64'(64));
        repeat (10) @(negedge clk);
        check_output("st_no_more", 64'(vcount), 64'(64));
        check_output("st_done_cnt", 64'(done_cnt), 64'(1));

        $display("[TB] closing flush");
        run(2'b00, 28'h40, 1'b1, -1, 1'b0);
        check_output("fl_count", 64'(seen.size()), 64'(5));
        check_output("fl_last", 64'({seen[4].fl, seen[4].rw}), 64'(2'b10));

        $display("[TB] address wrap");
        run(2'b10, 28'hFFF_FFFE, 1'b0, -1, 1'b0);
        check_output("wr_addr2", 64'(seen[2].addr), 64'(0));
        check_output("wr_data2", 64'(seen[2].data), 64'(32'hA5A5_0000));

        $display("[TB] start while busy");
        apply_stimulus(2'b01, 28'h500, 1'b0, -1, 1'b0);
        repeat (3) @(negedge clk);
        base_addr = 28'h777; mode = 2'b10; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(600);
        check_output("sb_count", 64'(seen.size()), 64'(4));

        $display("[TB] reset during wait");
        apply_stimulus(2'b11, 28'h900, 1'b1, -1, 1'b1);
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1 check_reset_outputs();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        stuck = 1'b0;
        run(2'b10, 28'h2000, 1'b1, 1, 1'b0);
        check_output("ar_err", 64'(err_cnt), 64'(1));
        check_output("ar_first", 64'(first_err_addr), 64'(28'h2001));

        $display("[TB] randomized runs");
        for (int r = 0; r < 10; r++) begin
            run(2'($urandom), ($urandom_range(0, 3) == 0) ? 28'hFFF_FFFD : ADDR_W'($urandom),
                1'($urandom), $urandom_range(0, 4) - 1, 1'b0);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/cache_traffic_gen.md
# cache_traffic_gen

Synthesizable request generator for the unified cache front end: drives the same `cache_addr`/`cache_wr`/`cache_rw`/`cache_valid`/`flush` request port the directed benches drive by hand, and checks `cache_rd`. It issues a parametrised burst of reads, or writes followed by readback, at unit or set-conflict stride, with an optional closing flush. Sits between a debug/control register block and the cache, replacing hand-written stimulus for on-board cache/DDR2 soak testing.

## Interface
Parameters:
- `ADDR_W`, 28: cache address width.
- `DATA_W`, 32: cache data width.
- `N_REQ`, 16: requests per pass, ≥2.
- `STRIDE`, 28'h100_0000: conflict-mode address step; same index, next tag.
- `SEED`, 32'hA5A5_0000: write/compare pattern seed.
- `TIMEOUT`, 1024: maximum cycles waiting for `cache_ready`.
- `ERR_W`, 16: error counter width.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle start pulse; ignored while `busy`.
- `mode` in 2: bit0 selects the step (0 = step 1, 1 = `STRIDE`). Bit1 selects the pass structure (0 = read pass only, 1 = write pass then readback pass).
- `do_flush` in 1: issue a flush transaction after the last pass.
- `base_addr` in ADDR_W: first address.
- `cache_addr` out ADDR_W, `cache_wr` out DATA_W, `cache_rw` out 1 (1 = write), `cache_valid` out 1, `flush` out 1: request port.
- `cache_rd` in DATA_W, `cache_ready` in 1: completion port.
- `busy` out 1, `done` out 1: status; `done` is a one-cycle pulse.
- `err_cnt` out ERR_W, `first_err_addr` out ADDR_W, `timeout` out 1: results.

## Operation
- `mode`, `base_addr` and `do_flush` are latched at `start`. `err_cnt`, `first_err_addr` and `timeout` clear at `start`.
- Address for index i is `base_addr + i` or `base_addr + i*STRIDE`, computed modulo 2^ADDR_W. Wrap-around is legal.
- Pattern is `SEED ^ addr`, with the address zero-extended or truncated to DATA_W.
- States:
  - IDLE: go to ISSUE on `start`.
  - ISSUE: drive the request. Always go to WAIT.
  - WAIT: hold the request. On `cache_ready`, go to GAP. On timeout, go to DONE.
  - GAP: one cycle with `cache_valid` low. Then go to ISSUE for the next index, the next pass, or FLUSH; if none remain, go to DONE.
  - FLUSH: assert `flush` and `cache_valid` with `cache_rw`=0 until `cache_ready`, then go to DONE.
  - DONE: pulse `done`, then go to IDLE.
- Readback pass: at the `cache_ready` edge, compare `cache_rd` against the pattern. On mismatch, increment `err_cnt`, saturating at all-ones. Capture `first_err_addr` only on the first mismatch.
- No compare is made in read-only mode or during the write pass.
- `cache_ready` while `cache_valid` is low is ignored.
- Timeout: a per-request counter reaches TIMEOUT while in WAIT or FLUSH. Then set `timeout`, drop the request, go to DONE, and skip all remaining requests.

## Timing
- Reset (asynchronous, immediate) drives every output to 0 and the state to IDLE, including mid-transaction.
- `start` sampled at edge t gives `cache_valid`=1 with a stable request from t+1.
- The request is held unchanged until `cache_ready` is sampled high at edge k. `cache_valid` is low in cycle k+1 (GAP). The next request is valid from k+2.
- `err_cnt` and `first_err_addr` update at edge k and are visible in cycle k+1.
- `done` goes high for one cycle, two cycles after the last completion edge. `busy` is high from t+1 through the `done` cycle.
- `busy` and `done` are never high in the same cycle as IDLE.

## Structure
- Package `cache_tg_pkg` holds:
  - the state enum;
  - the `mode` bit-position constants;
  - the `$clog2`-derived index and timeout counter widths.
- Sub-module `cache_tg_pattern_gen` is combinational: index, mode and base in; address and pattern out.
- The FSM, counters and checker live in the top module.

## Test plan
All scenarios use `N_REQ`=4, `TIMEOUT`=64, and a responsive cache model.
- Read-only, unit step: `mode`=00, `base_addr`=0 → reads at 0,1,2,3 with `cache_rw`=0; `done` after 4 completions; `err_cnt`=0; `timeout`=0.
- Conflict writes then readback: `mode`=11, `base_addr`=28'h000_1018.
  - Writes go to 000_1018, 100_1018, 200_1018 and 300_1018, with `cache_wr` A5A5_1018, A4A5_1018, A7A5_1018 and A6A5_1018.
  - Reads then go to the same addresses in the same order; `err_cnt`=0.
- Corrupted readback: same as the previous scenario, with the model returning 0 for the third read → `err_cnt`=1; `first_err_addr`=28'h200_1018.
- Stuck cache: the model never asserts `cache_ready` → `timeout`=1 exactly 64 cycles after `cache_valid` rises; `cache_valid` drops; one `done` pulse; no further requests.
- Flush: `do_flush`=1, `mode`=00 → after the 4th read and the GAP cycle, `flush`=`cache_valid`=1 and `cache_rw`=0 until ready; then `done`.
- Robustness:
  - A `start` pulse while `busy` is ignored.
  - Driving `rst` low in WAIT zeroes all outputs immediately.
  - After `rst` is released, a new `start` runs normally.
